cpu_run_monitor: RTL and testbench
==================================

# cpu_run_monitor

Synthesizable run monitor sitting directly downstream of the single-cycle MIPS core (`top`). It taps the core's PC and register-file write-back port, and counts cycles and retired instructions. It detects program completion, either a branch-to-self halt or a cycle timeout. It then presents the final n/fib(n) result (`$s0`/`$s1`) to a host over a valid/ready handshake, replacing the hard-coded end-of-sim bench print.

## Interface
Parameters:
- `HALT_REPEAT`, 2, consecutive edges with unchanged PC that declare a halt (≥1)
- `MAX_CYCLES`, 90, cycle budget before timeout (90 × 20 ns = 1800 ns)
- `N_REG`, 16, register index shadowed as n (`$s0`)
- `R_REG`, 17, register index shadowed as result (`$s1`)

Ports:
- `clk`  in  1  core clock; one clock domain
- `rst`  in  1  asynchronous, active-high reset
- `pc`  in  32  core PC (`pc_in`)
- `wb_en`  in  1  register-file write enable
- `wb_addr`  in  5  write-back register index
- `wb_data`  in  32  write-back data (`r_wbdata`)
- `mem_we`  in  1  data-memory write enable (`c_MemWrite`)
- `mem_addr`  in  32  data-memory address
- `mem_wdata`  in  32  data-memory write data
- `res_ready`  in  1  host accepts report
- `res_valid`  out  1  report available
- `res_n`  out  32  shadowed `N_REG` value
- `res_fib`  out  32  shadowed `R_REG` value
- `res_timeout`  out  1  1 means the run ended by budget, not halt
- `cycle_cnt`  out  32  cycles spent in RUN
- `instr_cnt`  out  32  distinct-PC retirements
- `busy`  out  1  high in RUN

## Operation
- FSM states: RUN, REPORT, DONE. Reset state is RUN.
- RUN:
  - `cycle_cnt` increments every edge.
  - `instr_cnt` increments when `pc` differs from the previously sampled PC.
  - The first edge after reset only loads `pc_q`; a valid flag suppresses matching on that edge.
- Halt detector:
  - `same_cnt` increments when `pc == pc_q`; otherwise it clears.
  - When `same_cnt` reaches `HALT_REPEAT`, go to REPORT with `res_timeout=0`.
- Timeout: when `cycle_cnt == MAX_CYCLES-1` with no halt, go to REPORT with `res_timeout=1`.
- Simultaneous halt and timeout: halt wins, `res_timeout=0`.
- Shadowing: on `wb_en && wb_addr==N_REG`, load `res_n`; likewise `R_REG` loads `res_fib`.
  - `wb_addr==0` is never shadowed, even if a parameter is 0.
  - Shadow updates occur only in RUN.
- REPORT:
  - `res_valid=1`; all `res_*` outputs and counters are frozen.
  - On `res_valid && res_ready`, go to DONE.
- DONE: `res_valid=0`, values held; leaves only via `rst`.
- Counters saturate at 0xFFFFFFFF; they never wrap.

## Timing
- Reset values:
  - `res_valid`, `res_timeout`, `busy`: 0.
  - `res_n`, `res_fib`, `cycle_cnt`, `instr_cnt`: 0.
  - `busy` rises on the first edge after `rst` deasserts.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency:
  - Halt: `res_valid` rises on the same edge that sees the `HALT_REPEAT`-th consecutive PC match.
  - Timeout: `res_valid` rises on the edge where `cycle_cnt` would reach `MAX_CYCLES`.
- Handshake:
  - `res_valid` holds until accepted; data is stable while valid.
  - `res_ready` may be high before valid; acceptance then happens on the first valid cycle, and valid lasts exactly one cycle.
- A write-back on the same edge as halt detection is captured before freezing.
- `rst` asserted mid-run or mid-REPORT immediately clears all state, with no pending handshake.

## Configuration
- `CPU_MON_MEMTRACE_EN` defined:
  - Adds outputs `st_cnt` (32), `st_last_addr` (32), `st_last_data` (32).
  - These count and record data-memory stores in RUN; all reset to 0 and freeze outside RUN.
- Undefined: those ports and logic do not exist; `mem_we`, `mem_addr`, `mem_wdata` are ignored (ports kept).

## Structure
- Package `cpu_mon_pkg`:
  - state enum `mon_state_t` (RUN, REPORT, DONE)
  - default constants `MON_N_REG=16`, `MON_R_REG=17`, `MON_MAX_CYCLES=90`
- Sub-module `halt_detector`:
  - holds `pc_q`, valid flag and `same_cnt`
  - parameter `HALT_REPEAT`; output `halt_pulse`

## Test plan
- Fibonacci program, n=10 in `$s0`, ends in `beq $0,$0,-1` → `res_valid` with `res_n=10`, `res_fib=55`, `res_timeout=0`, `instr_cnt` equal to the instruction-trace count.
- Never-halting PC ramp, `MAX_CYCLES=90` → `res_valid` after 90 RUN cycles, `res_timeout=1`, `cycle_cnt=90`.
- Halt reached with `res_ready=0` for 5 cycles, then 1 → valid for exactly 6 cycles with data stable, then DONE with `res_valid=0`.
- `wb_en` with `wb_addr=0`, data 0xDEADBEEF, plus a write to `$s1`=0x15 → `res_fib=0x15`, no corruption.
- `rst` pulsed during RUN at cycle 30 → all outputs 0 within the reset; the rerun reports identical counts to a clean run.
- `CPU_MON_MEMTRACE_EN`, store 0x37 to address 0x1C → `st_cnt=1`, `st_last_addr=0x1C`, `st_last_data=0x37`.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// Shared types and defaults for the CPU run monitor.
package cpu_mon_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REPORT = 2'd1,
    DONE   = 2'd2
  } mon_state_t;

  localparam int MON_N_REG      = 16;
  localparam int MON_R_REG      = 17;
  localparam int MON_MAX_CYCLES = 90;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_run_monitor_halt_detector.sv
// Branch-to-self detector: flags HALT_REPEAT consecutive edges with an unchanged PC.
module halt_detector #(
  parameter int HALT_REPEAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  output logic        pc_new_o,
  output logic        halt_pulse_o
);

  localparam int CW = (HALT_REPEAT < 2) ? 1 : $clog2(HALT_REPEAT + 1);

  logic [31:0]   pc_q;
  logic          pc_vld_q;
  logic [CW-1:0] same_cnt_q;
  logic          match;

  // The first sampled PC has nothing to compare against.
  assign match        = pc_vld_q && (pc_i == pc_q);
  assign pc_new_o     = pc_vld_q && (pc_i != pc_q);
  assign halt_pulse_o = en_i && match && (same_cnt_q == CW'(HALT_REPEAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      pc_vld_q   <= 1'b0;
      same_cnt_q <= '0;
    end else if (en_i) begin
      pc_q       <= pc_i;
      pc_vld_q   <= 1'b1;
      same_cnt_q <= match ? same_cnt_q + CW'(1) : '0;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor for the single-cycle MIPS core: counts, halt/timeout detection, result report.
// Optional store tracing is enabled by defining CPU_MON_MEMTRACE_EN.
//
// state  | meaning
// RUN    | program executing; counters, shadows and halt detector live
// REPORT | result presented with res_valid until the host takes it
// DONE   | report accepted; everything held until reset
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int HALT_REPEAT = 2,
  parameter int MAX_CYCLES  = MON_MAX_CYCLES,
  parameter int N_REG       = MON_N_REG,
  parameter int R_REG       = MON_R_REG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        res_ready,
  output logic        res_valid,
  output logic [31:0] res_n,
  output logic [31:0] res_fib,
  output logic        res_timeout,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
  output logic        busy
`ifdef CPU_MON_MEMTRACE_EN
  ,
  output logic [31:0] st_cnt,
  output logic [31:0] st_last_addr,
  output logic [31:0] st_last_data
`endif
);

  mon_state_t  state_q, state_d;
  logic        timeout_q, timeout_d;
  logic        valid_q, busy_q;
  logic [31:0] res_n_q, res_fib_q, cycle_cnt_q, instr_cnt_q;
  logic        run, pc_new, halt_pulse;

  assign run = (state_q == RUN);

  halt_detector #(.HALT_REPEAT(HALT_REPEAT)) u_halt (
    .clk          (clk),
    .rst          (rst),
    .en_i         (run),
    .pc_i         (pc),
    .pc_new_o     (pc_new),
    .halt_pulse_o (halt_pulse)
  );

  // Halt is checked first so a coincident timeout still reports a clean halt.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (halt_pulse) begin
          state_d   = REPORT;
          timeout_d = 1'b0;
        end else if (cycle_cnt_q == 32'(MAX_CYCLES - 1)) begin
          state_d   = REPORT;
          timeout_d = 1'b1;
        end
      end
      REPORT: if (valid_q && res_ready) state_d = DONE;
      DONE:   state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      timeout_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_n_q     <= '0;
      res_fib_q   <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      valid_q   <= (state_d == REPORT);
      busy_q    <= (state_d == RUN);
      // The halting edge is still a RUN edge, so its write-back and counts land.
      if (run) begin
        cycle_cnt_q <= sat_inc(cycle_cnt_q);
        if (pc_new) instr_cnt_q <= sat_inc(instr_cnt_q);
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == 5'(N_REG))) res_n_q   <= wb_data;
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == 5'(R_REG))) res_fib_q <= wb_data;
      end
    end
  end

  assign res_valid   = valid_q;
  assign res_timeout = timeout_q;
  assign busy        = busy_q;
  assign res_n       = res_n_q;
  assign res_fib     = res_fib_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instr_cnt   = instr_cnt_q;

`ifdef CPU_MON_MEMTRACE_EN
  logic [31:0] st_cnt_q, st_addr_q, st_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt_q  <= '0;
      st_addr_q <= '0;
      st_data_q <= '0;
    end else if (run && mem_we) begin
      st_cnt_q  <= sat_inc(st_cnt_q);
      st_addr_q <= mem_addr;
      st_data_q <= mem_wdata;
    end
  end

  assign st_cnt       = st_cnt_q;
  assign st_last_addr = st_addr_q;
  assign st_last_data = st_data_q;
`else
  logic unused_mem;
  assign unused_mem = ^{mem_we, mem_addr, mem_wdata};
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized bench for cpu_run_monitor against a trace-level reference model.
module tb_cpu_run_monitor;

  localparam int HR   = 2;
  localparam int MAXC = 90;
  localparam int NR   = 16;
  localparam int RR   = 17;
  localparam int TMAX = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        res_ready = 1'b0;
  logic        res_valid, res_timeout, busy;
  logic [31:0] res_n, res_fib, cycle_cnt, instr_cnt;
`ifdef CPU_MON_MEMTRACE_EN
  logic [31:0] st_cnt, st_last_addr, st_last_data;
`endif

  cpu_run_monitor #(.HALT_REPEAT(HR), .MAX_CYCLES(MAXC), .N_REG(NR), .R_REG(RR)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .res_ready   (res_ready),
    .res_valid   (res_valid),
    .res_n       (res_n),
    .res_fib     (res_fib),
    .res_timeout (res_timeout),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt),
    .busy        (busy)
`ifdef CPU_MON_MEMTRACE_EN
    ,
    .st_cnt       (st_cnt),
    .st_last_addr (st_last_addr),
    .st_last_data (st_last_data)
`endif
  );

  always #10 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Stimulus trace, indexed by edge number after reset release.
  logic [31:0] t_pc [1:TMAX];
  logic        t_we [1:TMAX];
  logic [4:0]  t_wa [1:TMAX];
  logic [31:0] t_wd [1:TMAX];
  bit          mem_dir;

  int          e_end;
  bit          e_to;
  logic [31:0] e_n, e_fib, e_ic;

  // Reference: locate the first window of HR repeated PCs, clip at the cycle budget,
  // then replay counts and register writes up to that edge.
  task automatic model();
    int  halt_e;
    bit  all_eq;
    halt_e = TMAX + 1;
    for (int e = HR + 1; e <= TMAX && halt_e > TMAX; e++) begin
      all_eq = 1'b1;
      for (int j = 0; j < HR; j++)
        if (t_pc[e - j] != t_pc[e - j - 1]) all_eq = 1'b0;
      if (all_eq) halt_e = e;
    end
    e_to  = (halt_e > MAXC);
    e_end = e_to ? MAXC : halt_e;
    e_ic  = 0;
    e_n   = 0;
    e_fib = 0;
    for (int e = 1; e <= e_end; e++) begin
      if (e >= 2 && t_pc[e] != t_pc[e - 1]) e_ic++;
      if (t_we[e] && t_wa[e] != 0 && t_wa[e] == 5'(NR)) e_n   = t_wd[e];
      if (t_we[e] && t_wa[e] != 0 && t_wa[e] == 5'(RR)) e_fib = t_wd[e];
    end
  endtask

  task automatic rand_wb();
    for (int e = 1; e <= TMAX; e++) begin
      t_we[e] = ($urandom % 3 == 0);
      case ($urandom % 4)
        0: t_wa[e] = 5'd0;
        1: t_wa[e] = 5'(NR);
        2: t_wa[e] = 5'(RR);
        default: t_wa[e] = 5'($urandom);
      endcase
      t_wd[e] = $urandom;
    end
  endtask

  // 0: random program then halt, 1: fib(10), 2: never-halting ramp, 3: $0/$s1 writes
  task automatic gen(input int mode);
    int len;
    logic [31:0] f0, f1, tmp;
    mem_dir = 1'b0;
    for (int e = 1; e <= TMAX; e++) begin
      t_we[e] = 1'b0; t_wa[e] = '0; t_wd[e] = '0;
    end
    case (mode)
      0: begin
        rand_wb();
        len = $urandom_range(3, 100);
        t_pc[1] = 32'($urandom_range(0, 1023)) << 2;
        for (int e = 2; e <= TMAX; e++) begin
          if (e > len) t_pc[e] = t_pc[e - 1];
          else case ($urandom % 10)
            0: t_pc[e] = t_pc[e - 1];
            1: t_pc[e] = t_pc[e - 1] - 32'(4 * $urandom_range(1, 4));
            default: t_pc[e] = t_pc[e - 1] + 32'd4;
          endcase
        end
      end
      1: begin
        for (int e = 1; e <= TMAX; e++) t_pc[e] = (e <= 17) ? 32'(4 * (e - 1)) : 32'h44;
        t_we[1] = 1'b1; t_wa[1] = 5'(NR); t_wd[1] = 32'd10;
        f0 = 0; f1 = 1;
        for (int e = 3; e <= 11; e++) begin
          t_we[e] = 1'b1; t_wa[e] = 5'(RR); t_wd[e] = f1;
          tmp = f0 + f1; f0 = f1; f1 = tmp;
        end
        t_we[20] = 1'b1; t_wa[20] = 5'(RR); t_wd[20] = f1;
      end
      2: begin
        rand_wb();
        for (int e = 1; e <= TMAX; e++) t_pc[e] = 32'(4 * e);
      end
      default: begin
        for (int e = 1; e <= TMAX; e++) t_pc[e] = (e <= 8) ? 32'h100 + 32'(4 * e) : 32'h120;
        t_we[2] = 1'b1; t_wa[2] = 5'd0;    t_wd[2] = 32'hDEADBEEF;
        t_we[3] = 1'b1; t_wa[3] = 5'(RR);  t_wd[3] = 32'h15;
        t_we[4] = 1'b1; t_wa[4] = 5'd0;    t_wd[4] = 32'hDEADBEEF;
        mem_dir = 1'b1;
      end
    endcase
  endtask

  task automatic run_trace(input int abort_at, input bit rdy_early, input int hold);
    int got;
    rst = 1'b1; res_ready = 1'b0; wb_en = 1'b0; pc = '0; mem_we = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(res_timeout), 0);
    check("rst_cnts", cycle_cnt | instr_cnt | res_n | res_fib, 0);
    rst = 1'b0;
    got = 0;
    for (int e = 1; e <= MAXC + 5 && got == 0; e++) begin
      pc = t_pc[e]; wb_en = t_we[e]; wb_addr = t_wa[e]; wb_data = t_wd[e];
      mem_we = mem_dir && (e == 2);
      mem_addr = mem_we ? 32'h1C : $urandom;
      mem_wdata = mem_we ? 32'h37 : $urandom;
      res_ready = rdy_early;
      @(posedge clk); #1;
      if (e == abort_at) begin
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(res_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cnts", cycle_cnt | instr_cnt | res_n | res_fib, 0);
        return;
      end
      if (e == 1 && !res_valid) check("busy_rise", 32'(busy), 1);
      if (res_valid) got = e;
    end
    check("end_edge", got, e_end);
    check("timeout", 32'(res_timeout), 32'(e_to));
    check("res_n", res_n, e_n);
    check("res_fib", res_fib, e_fib);
    check("cycle_cnt", cycle_cnt, e_end);
    check("instr_cnt", instr_cnt, e_ic);
    check("busy_report", 32'(busy), 0);
    if (got == 0) return;
    wb_en = 1'b1; wb_addr = 5'(RR); wb_data = $urandom; pc = $urandom; mem_we = 1'b1;
    if (!rdy_early) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(res_valid), 1);
        check("hold_fib", res_fib, e_fib);
        check("hold_cycle", cycle_cnt, e_end);
      end
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("accept_valid", 32'(res_valid), 0);
    res_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("done_valid", 32'(res_valid), 0);
      check("done_fib", res_fib, e_fib);
      check("done_cycle", cycle_cnt, e_end);
      check("done_instr", instr_cnt, e_ic);
    end
    wb_en = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    gen(1); model(); run_trace(0, 1'b0, 5);
    check("fib_n", res_n, 32'd10);
    check("fib_result", res_fib, 32'd55);
    check("fib_timeout", 32'(res_timeout), 0);

    gen(2); model(); run_trace(0, 1'b1, 0);
    check("to_flag", 32'(res_timeout), 1);
    check("to_cycles", cycle_cnt, 32'd90);

    gen(3); model(); run_trace(0, 1'b0, 2);
    check("s1_value", res_fib, 32'h15);
    check("s0_clean", res_n, 32'h0);
`ifdef CPU_MON_MEMTRACE_EN
    check("st_cnt", st_cnt, 32'd1);
    check("st_addr", st_last_addr, 32'h1C);
    check("st_data", st_last_data, 32'h37);
`endif

    gen(2); model(); run_trace(30, 1'b0, 0); run_trace(0, 1'b0, 1);

    for (int r = 0; r < 10; r++) begin
      gen(0); model(); run_trace(0, 1'($urandom % 2), $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
